gb_irq_ctrl: RTL and testbench
==============================

Name: gb_irq_ctrl

Overview:
- Game Boy interrupt controller: latches the emulator's interrupt requests and exposes IF/IE/IME semantics.
- Request sources: vblank, LCD STAT, timer, serial, joypad. The timer request comes from the interval timer's irq output.
- Produces one prioritized, registered irq and a vector for the Nios CPU.
- Register access is through an Avalon-MM slave with the same bus shape as the system timer: 3-bit address, 16-bit data, registered reads.

Parameters:
- NUM_SRC, 5, number of interrupt sources (1..8). Bit 0 has the highest priority.
- LEVEL_MASK, 5'b00000, per-source mode: 1 = level-sensitive, 0 = rising-edge.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  Avalon register select.
- chipselect  in  1  Avalon chip select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  16  Avalon write data.
- readdata  out  16  Avalon read data, registered.
- irq_src  in  NUM_SRC  interrupt request lines, synchronous to clk.
- irq  out  1  interrupt to the Nios CPU, registered.
- irq_vector  out  3  index of the highest-priority pending enabled source; 0 when none.

Behaviour:
- Register map. Bits above NUM_SRC-1 read as 0 and are ignored on write.
  - Addr 0, IF (flags): read/write.
  - Addr 1, IE (enables): read/write.
  - Addr 2, PENDING = IF & IE: read-only.
  - Addr 3, VECTOR.
    - Read: {valid in bit15, 12'b0, index in [2:0]}.
    - Write: ACK, clears IF[writedata[2:0]]. An index >= NUM_SRC has no effect.
  - Addr 4, CTRL: bit0 = IME (master enable), read/write.
  - Addr 5..7: read 0, writes ignored.
- Write strobe = chipselect && ~write_n. Reads are not side-effecting.
- readdata updates every clock from the address mux, giving 1-cycle read latency.
- Edge detection: prev_src is registered each cycle.
  - Edge-mode source: set_evt[i] = irq_src[i] & ~prev_src[i].
  - Level-mode source: set_evt[i] = irq_src[i].
- IF next state, per bit:
  - set_evt[i] = 1 sets IF[i] = 1. This overrides any same-cycle write or ACK, so hardware events are never lost.
  - Otherwise an IF write loads writedata[i].
  - Otherwise an ACK targeting i clears IF[i].
  - Otherwise IF[i] holds.
- Level-mode source held high: IF re-sets every cycle, so ACK/clear only sticks once the source drops.
- pend = IF & IE, computed from current register values.
- irq_vector is combinational: the lowest set index of pend.
- valid = |pend. This is independent of IME, so software can poll with IME = 0.
- irq register: irq <= IME && |pend.
  - A source edge at cycle N sets IF at N+1 and raises irq at N+2.
  - irq drops one cycle after the pend condition clears (ACK, IE clear, or IME clear).
- Reset, asynchronous, any time including mid-transaction:
  - IF = 0, IE = 0, IME = 0, prev_src = 0.
  - readdata = 16'h0000, irq = 0.
  - irq_vector reads 0, because pend = 0.
- After reset release, a source already high in edge mode is seen as an edge on the first clock and sets its flag.
- Multiple simultaneous edges set all their flags in the same cycle. The vector reports the lowest index; ACKing it exposes the next one.

Test Plan:
- Reset, then read addr 0..7 -> all 0x0000; irq = 0; irq_vector = 0.
- IE = 0x1F, IME = 1; pulse irq_src[2] for 1 cycle at cycle N -> IF = 0x04 at N+1; irq = 1 at N+2; VECTOR reads 0x8002 (valid, index 2); write ACK 2 -> IF = 0x00 and irq = 0 two cycles later.
- Edges on sources 4 and 1 in the same cycle, IE = 0x1F -> VECTOR = 0x8001; after ACK 1 -> VECTOR = 0x8004; after ACK 4 -> 0x0000.
- ACK 3 in the same cycle as a new edge on source 3 -> IF[3] remains 1 and irq stays 1. Also write IF = 0x00 coincident with an edge on source 0 -> IF = 0x01.
- IME = 0, IE = 0x01, source 0 edge -> irq stays 0, PENDING reads 0x0001; set IME = 1 -> irq = 1 two cycles after the write.
- LEVEL_MASK = 5'b00001, source 0 held high -> ACK 0 leaves IF[0] = 1. Drop source 0, then ACK 0 -> IF[0] = 0. Assert reset_n low mid-sequence -> irq and readdata go 0 immediately (asynchronously).

Source files
------------

// File: rtl/gb_irq_ctrl_if.sv
// Avalon-MM register port of the interrupt controller: 3-bit address, 16-bit data.
// Same bus shape as the system timer; readdata is registered by the slave.
interface gb_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gb_irq_ctrl.sv
// Game Boy IF/IE/IME interrupt controller: source edge at N sets IF at N+1, irq at N+2; reads 1 cycle.
// No backpressure: a write is accepted every cycle, and hardware set events always win over software clears.
module gb_irq_ctrl #(
  parameter int                 NUM_SRC    = 5,
  parameter logic [NUM_SRC-1:0] LEVEL_MASK = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  gb_irq_ctrl_if.slave       bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  output logic [2:0]         irq_vector
);

  localparam logic [2:0] A_IF   = 3'd0;
  localparam logic [2:0] A_IE   = 3'd1;
  localparam logic [2:0] A_PEND = 3'd2;
  localparam logic [2:0] A_VEC  = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;

  logic [NUM_SRC-1:0] if_q, ie_q, prev_src_q;
  logic [NUM_SRC-1:0] if_d, set_evt, pend, wdat;
  logic               ime_q;
  logic               wr_en;
  logic [15:0]        rd_d;
  logic               unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdat         = bus.writedata[NUM_SRC-1:0];
  assign unused_wdata = ^bus.writedata;

  // Level-mode sources ignore the previous sample, so a held line re-sets IF every cycle.
  assign set_evt = irq_src & (LEVEL_MASK | ~prev_src_q);
  assign pend    = if_q & ie_q;

  always_comb begin
    if_d = if_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (set_evt[i]) begin
        if_d[i] = 1'b1;
      end else if (wr_en && bus.address == A_IF) begin
        if_d[i] = wdat[i];
      end else if (wr_en && bus.address == A_VEC && bus.writedata[2:0] == 3'(i)) begin
        if_d[i] = 1'b0;
      end
    end
  end

  // Scan from the top so the lowest pending index is the one left standing.
  always_comb begin
    irq_vector = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        irq_vector = 3'(i);
      end
    end
  end

  always_comb begin
    rd_d = 16'h0000;
    case (bus.address)
      A_IF:    rd_d = 16'(if_q);
      A_IE:    rd_d = 16'(ie_q);
      A_PEND:  rd_d = 16'(pend);
      A_VEC:   rd_d = {|pend, 12'b0, irq_vector};
      A_CTRL:  rd_d = {15'b0, ime_q};
      default: rd_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_q         <= '0;
      ie_q         <= '0;
      ime_q        <= 1'b0;
      prev_src_q   <= '0;
      bus.readdata <= 16'h0000;
      irq          <= 1'b0;
    end else begin
      if_q         <= if_d;
      prev_src_q   <= irq_src;
      bus.readdata <= rd_d;
      irq          <= ime_q && (|pend);
      if (wr_en && bus.address == A_IE) begin
        ie_q <= wdat;
      end
      if (wr_en && bus.address == A_CTRL) begin
        ime_q <= bus.writedata[0];
      end
    end
  end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Directed bench for gb_irq_ctrl with source 0 level-sensitive and sources 1..4 edge-sensitive.
module tb_gb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] src = '0;
  logic       irq;
  logic [2:0] vec;
  logic [15:0] rdv;
  int checks = 0;
  int failures = 0;

  gb_irq_ctrl_if bus();

  gb_irq_ctrl #(.NUM_SRC(5), .LEVEL_MASK(5'b00001)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .irq_src    (src),
    .irq        (irq),
    .irq_vector (vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset state
    #12;
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_rdata", bus.readdata, 16'h0);
    chk("rst_vec", 16'(vec), 16'h0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rdv);
      chk($sformatf("rst_rd%0d", a), rdv, 16'h0000);
    end

    // Single edge on source 2, then ACK
    wr(3'd1, 16'h001F);
    wr(3'd4, 16'h0001);
    src = 5'b00100;
    tick();
    src = '0;
    chk("s2_irq_n1", 16'(irq), 16'h0);
    rd(3'd0, rdv);
    chk("s2_if", rdv, 16'h0004);
    chk("s2_irq_n2", 16'(irq), 16'h1);
    chk("s2_vec", 16'(vec), 16'h2);
    rd(3'd3, rdv);
    chk("s2_vecreg", rdv, 16'h8002);
    wr(3'd3, 16'h0002);
    chk("s2_ack_irq_hold", 16'(irq), 16'h1);
    tick();
    chk("s2_ack_irq_drop", 16'(irq), 16'h0);
    rd(3'd0, rdv);
    chk("s2_if_clr", rdv, 16'h0000);

    // Simultaneous edges on 4 and 1
    src = 5'b10010;
    tick();
    src = '0;
    tick();
    chk("m_vec", 16'(vec), 16'h1);
    rd(3'd3, rdv);
    chk("m_vec1", rdv, 16'h8001);
    wr(3'd3, 16'h0001);
    rd(3'd3, rdv);
    chk("m_vec4", rdv, 16'h8004);
    wr(3'd3, 16'h0004);
    rd(3'd3, rdv);
    chk("m_vec_none", rdv, 16'h0000);

    // ACK 3 racing a fresh edge on source 3
    src = 5'b01000;
    tick();
    src = '0;
    tick();
    tick();
    src = 5'b01000;
    wr(3'd3, 16'h0003);
    src = '0;
    rd(3'd0, rdv);
    chk("race_ack_if", rdv, 16'h0008);
    chk("race_ack_irq", 16'(irq), 16'h1);
    wr(3'd3, 16'h0003);
    rd(3'd0, rdv);
    chk("race_ack_clr", rdv, 16'h0000);

    // IF write racing an event on source 0
    src = 5'b00010;
    tick();
    src = '0;
    tick();
    src = 5'b00001;
    wr(3'd0, 16'h0000);
    src = '0;
    rd(3'd0, rdv);
    chk("race_wr_if", rdv, 16'h0001);
    wr(3'd0, 16'h0000);
    rd(3'd0, rdv);
    chk("race_wr_clr", rdv, 16'h0000);

    // IME gating
    wr(3'd4, 16'h0000);
    wr(3'd1, 16'h0001);
    src = 5'b00001;
    tick();
    src = '0;
    tick();
    tick();
    chk("ime0_irq", 16'(irq), 16'h0);
    rd(3'd2, rdv);
    chk("ime0_pend", rdv, 16'h0001);
    rd(3'd3, rdv);
    chk("ime0_poll", rdv, 16'h8000);
    wr(3'd4, 16'h0001);
    chk("ime1_irq_n1", 16'(irq), 16'h0);
    tick();
    chk("ime1_irq_n2", 16'(irq), 16'h1);
    rd(3'd4, rdv);
    chk("ime_rd", rdv, 16'h0001);
    wr(3'd3, 16'h0000);
    tick();
    tick();
    chk("ime_ack_irq", 16'(irq), 16'h0);

    // Level mode on source 0 held high
    wr(3'd1, 16'h001F);
    src = 5'b00001;
    tick();
    tick();
    wr(3'd3, 16'h0000);
    rd(3'd0, rdv);
    chk("lvl_ack_held", rdv, 16'h0001);
    src = '0;
    tick();
    wr(3'd3, 16'h0000);
    rd(3'd0, rdv);
    chk("lvl_ack_drop", rdv, 16'h0000);
    chk("lvl_irq", 16'(irq), 16'h0);

    // Edge mode on source 2 held high: ACK sticks
    src = 5'b00100;
    tick();
    tick();
    wr(3'd3, 16'h0002);
    tick();
    rd(3'd0, rdv);
    chk("edge_hold_ack", rdv, 16'h0000);
    src = '0;
    tick();

    // Upper bits ignored, unused addresses
    wr(3'd1, 16'hFFE0);
    rd(3'd1, rdv);
    chk("ie_upper", rdv, 16'h0000);
    wr(3'd1, 16'h001F);
    wr(3'd6, 16'hFFFF);
    rd(3'd6, rdv);
    chk("addr6", rdv, 16'h0000);

    // Asynchronous reset mid-sequence
    src = 5'b00010;
    tick();
    src = '0;
    tick();
    rd(3'd0, rdv);
    chk("pre_rst_irq", 16'(irq), 16'h1);
    chk("pre_rst_rd", rdv, 16'h0002);
    #2;
    reset_n = 1'b0;
    src = 5'b00100;
    #1;
    chk("arst_irq", 16'(irq), 16'h0);
    chk("arst_rdata", bus.readdata, 16'h0000);
    chk("arst_vec", 16'(vec), 16'h0);
    #3;
    reset_n = 1'b1;
    tick();
    rd(3'd0, rdv);
    chk("post_rst_edge", rdv, 16'h0004);
    rd(3'd1, rdv);
    chk("post_rst_ie", rdv, 16'h0000);
    rd(3'd4, rdv);
    chk("post_rst_ime", rdv, 16'h0000);
    chk("post_rst_irq", 16'(irq), 16'h0);
    src = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
